pellet_eater: RTL and testbench
===============================

PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001 SHALL have parameter SCORE_PER_PELLET, default 10, score added per pellet eaten.
REQ-002 SHALL have parameter PELLET_TOTAL, default 600, pellet count loaded at reset and new level.
REQ-003 SHALL have port i_clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port i_tick, input, 1, one-cycle request to check Pac-Man's current tile.
REQ-006 SHALL have port i_pac_x, input, 6, Pac-Man tile column.
REQ-007 SHALL have port i_pac_y, input, 5, Pac-Man tile row.
REQ-008 SHALL have port i_new_level, input, 1, synchronous level restart.
REQ-009 SHALL have port o_map_en, output, 1, map RAM enable.
REQ-010 SHALL have port o_map_write, output, 1, map RAM write (clears the tile).
REQ-011 SHALL have port o_map_x, output, 6, map RAM tile column.
REQ-012 SHALL have port o_map_y, output, 5, map RAM tile row.
REQ-013 SHALL have port i_map_value, input, 1, registered map RAM read data.
REQ-014 SHALL have port o_busy, output, 1, high in any state except IDLE.
REQ-015 SHALL have port o_eaten, output, 1, one-cycle pulse per pellet eaten.
REQ-016 SHALL have port o_score, output, 16, accumulated score.
REQ-017 SHALL have port o_pellets_left, output, 11, pellets remaining.
REQ-018 SHALL have port o_level_clear, output, 1, sticky flag set when o_pellets_left reaches 0.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, EVAL and CLEAR.
REQ-020 In IDLE, on i_tick=1 with i_pac_x<50, SHALL latch i_pac_x/i_pac_y into o_map_x/o_map_y and go to READ.
REQ-021 In IDLE, on i_tick=1 with i_pac_x>=50, SHALL ignore the request and stay in IDLE.
REQ-022 In READ, SHALL drive o_map_en=1 and o_map_write=0 for exactly one cycle, then go to EVAL.
REQ-023 In EVAL, SHALL sample i_map_value (valid one cycle after READ); if 1, go to CLEAR; if 0, go to IDLE.
REQ-024 In CLEAR, SHALL drive o_map_en=1 and o_map_write=1 for one cycle, pulse o_eaten, then go to IDLE.
REQ-025 On leaving CLEAR, o_score SHALL add SCORE_PER_PELLET, saturating at 16'hFFFF.
REQ-026 On leaving CLEAR, o_pellets_left SHALL decrement and SHALL NOT go below 0.
REQ-027 SHALL decode o_map_en and o_map_write from the current state only, and hold both at 0 in IDLE and EVAL.
REQ-028 SHALL hold o_map_x/o_map_y stable from READ through CLEAR.
REQ-029 SHALL drop, not queue, i_tick while o_busy=1.
REQ-030 Latency from tick to tile cleared SHALL be 3 cycles (tick cycle T, READ T+1, EVAL T+2, CLEAR T+3).
REQ-031 SHALL set o_level_clear on the edge where o_pellets_left becomes 0, and hold it until reset or i_new_level.
REQ-032 i_new_level=1 in any state SHALL force the next state to IDLE, reload o_pellets_left=PELLET_TOTAL, clear o_level_clear, and retain o_score.
REQ-033 A map access decoded in the same cycle as i_new_level SHALL still occur, but no score/count update from it SHALL apply.

Reset
REQ-034 While i_rst_n=0, SHALL hold state=IDLE, o_score=0, o_pellets_left=PELLET_TOTAL, and all of o_eaten, o_level_clear, o_map_x, o_map_y at 0.
REQ-035 Reset assertion mid-transaction SHALL abort immediately, with no write issued after assertion.

Structure
REQ-036 SHALL take MAP_W=50, MAP_H=32, the tile coordinate widths and the FSM state enum from shared package pacman_pkg.
REQ-037 SHALL be a single module with no sub-module; the saturating score adder is inline.

Verification
REQ-038 Tick at (3,1) on a tile holding 1 -> read on T+1, write on T+3, o_eaten at T+3, score 0->10, pellets_left 600->599.
REQ-039 Tick on a tile holding 0 -> one read, no write, score unchanged, o_busy low at T+3.
REQ-040 Second tick at T+1 and T+2 -> ignored; exactly one map transaction.
REQ-041 Score preloaded to 65530 by 7 eats -> o_score holds at 65535 (saturation).
REQ-042 PELLET_TOTAL=2 with two eats -> o_level_clear rises with pellets_left=0; i_new_level -> pellets_left=2, flag low, score retained.
REQ-043 i_rst_n asserted during EVAL -> no write issued, all outputs at reset values; tick with i_pac_x=55 -> no map access.

Source files
------------

// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Shared Pac-Man playfield geometry, tile coordinate types and
//               the pellet-eater FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

    localparam int MAP_W    = 50;
    localparam int MAP_H    = 32;
    localparam int TILE_X_W = 6;
    localparam int TILE_Y_W = 5;

    typedef logic [TILE_X_W-1:0] tile_x_t;
    typedef logic [TILE_Y_W-1:0] tile_y_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_CLEAR = 2'd3
    } eat_state_t;

endpackage
`default_nettype wire

// File: rtl/pellet_eater.sv
`default_nettype none
// ============================================================================
// Module      : pellet_eater
// Description : Checks Pac-Man's tile in the map RAM on request, clears the
//               pellet if present, and maintains score / pellet count /
//               level-clear status.
// Revision    : 1.0 - initial release
// ============================================================================
module pellet_eater
    import pacman_pkg::*;
#(
    parameter int SCORE_PER_PELLET = 10,
    parameter int PELLET_TOTAL     = 600
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input  logic [TILE_X_W-1:0] i_pac_x,
    input  logic [TILE_Y_W-1:0] i_pac_y,
    input  logic                i_new_level,
    output logic                o_map_en,
    output logic                o_map_write,
    output logic [TILE_X_W-1:0] o_map_x,
    output logic [TILE_Y_W-1:0] o_map_y,
    input  logic                i_map_value,
    output logic                o_busy,
    output logic                o_eaten,
    output logic [15:0]         o_score,
    output logic [10:0]         o_pellets_left,
    output logic                o_level_clear
);

    localparam logic [15:0]         c_score_inc     = 16'(SCORE_PER_PELLET);
    localparam logic [10:0]         c_pellet_reload = 11'(PELLET_TOTAL);
    localparam logic [TILE_X_W-1:0] c_map_w         = TILE_X_W'(MAP_W);

    eat_state_t    r_state;
    logic [15:0]   r_score;
    logic [10:0]   r_pellets_left;
    logic          r_level_clear;
    tile_x_t       r_map_x;
    tile_y_t       r_map_y;

    logic          w_tick_ok;
    logic [16:0]   w_score_sum;
    logic [15:0]   w_score_next;
    logic [10:0]   w_pellets_next;

    // Requests for columns outside the playfield are discarded at the door
    assign w_tick_ok      = i_tick && (i_pac_x < c_map_w);

    // Saturating score adder: the carry out of a 17-bit sum pins the score
    assign w_score_sum    = {1'b0, r_score} + {1'b0, c_score_inc};
    assign w_score_next   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    // Pellet count floors at zero
    assign w_pellets_next = (r_pellets_left != 11'd0) ? (r_pellets_left - 11'd1) : 11'd0;

    // Map strobes and status are pure decodes of the state register, so an
    // asynchronous reset kills any in-flight access immediately
    assign o_map_en       = (r_state == ST_READ) || (r_state == ST_CLEAR);
    assign o_map_write    = (r_state == ST_CLEAR);
    assign o_eaten        = (r_state == ST_CLEAR);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_map_x        = r_map_x;
    assign o_map_y        = r_map_y;
    assign o_score        = r_score;
    assign o_pellets_left = r_pellets_left;
    assign o_level_clear  = r_level_clear;

    // Tile-check FSM with score, pellet count and level-clear bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_score        <= 16'd0;
            r_pellets_left <= c_pellet_reload;
            r_level_clear  <= 1'b0;
            r_map_x        <= '0;
            r_map_y        <= '0;
        end else if (i_new_level) begin
            // A CLEAR in this cycle still writes the RAM (decoded from the
            // state), but its score/count update is deliberately dropped
            r_state        <= ST_IDLE;
            r_pellets_left <= c_pellet_reload;
            r_level_clear  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick_ok) begin
                        r_map_x <= i_pac_x;
                        r_map_y <= i_pac_y;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    r_state <= i_map_value ? ST_CLEAR : ST_IDLE;
                end
                ST_CLEAR: begin
                    r_state        <= ST_IDLE;
                    r_score        <= w_score_next;
                    r_pellets_left <= w_pellets_next;
                    if (w_pellets_next == 11'd0) begin
                        r_level_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pellet_eater.sv
`default_nettype none
// ============================================================================
// Module      : tb_pellet_eater
// Description : Self-checking bench for pellet_eater: table of single-tile
//               transactions, hand-written timing sequences, randomized
//               traffic against a transaction-level score/pellet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pellet_eater;
    import pacman_pkg::*;

    localparam int SPP = 10;
    localparam int PT  = 600;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_tick = 1'b0;
    logic [5:0]  i_pac_x = '0;
    logic [4:0]  i_pac_y = '0;
    logic        i_new_level = 1'b0;
    logic        i_map_value;
    logic        o_map_en, o_map_write, o_busy, o_eaten, o_level_clear;
    logic [5:0]  o_map_x;
    logic [4:0]  o_map_y;
    logic [15:0] o_score;
    logic [10:0] o_pellets_left;

    always #5 i_clk = ~i_clk;

    pellet_eater #(.SCORE_PER_PELLET(SPP), .PELLET_TOTAL(PT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
        .i_pac_x(i_pac_x), .i_pac_y(i_pac_y), .i_new_level(i_new_level),
        .o_map_en(o_map_en), .o_map_write(o_map_write),
        .o_map_x(o_map_x), .o_map_y(o_map_y), .i_map_value(i_map_value),
        .o_busy(o_busy), .o_eaten(o_eaten), .o_score(o_score),
        .o_pellets_left(o_pellets_left), .o_level_clear(o_level_clear)
    );

    // Map RAM model: tile contents are set by the stimulus before each tick;
    // the monitor counts accesses and records the last write address
    logic mem [0:63][0:31];
    logic r_rdata = 1'b0;
    int   rd_cnt = 0, wr_cnt = 0, eat_cnt = 0;
    int   last_wx = -1, last_wy = -1;
    assign i_map_value = r_rdata;

    always @(posedge i_clk) begin
        if (o_map_en) begin
            if (o_map_write) begin
                wr_cnt++;
                last_wx = int'(o_map_x);
                last_wy = int'(o_map_y);
            end else begin
                rd_cnt++;
                r_rdata <= mem[o_map_x][o_map_y];
            end
        end
        if (o_eaten) eat_cnt++;
    end

    int vectors = 0, miscompares = 0;
    int m_score = 0, m_pellets = PT;
    bit m_lc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level reference: what one tick does to the game state
    task automatic model_tick(input int x, input bit v);
        if (x < MAP_W && v) begin
            m_score   = (m_score + SPP > 65535) ? 65535 : m_score + SPP;
            m_pellets = (m_pellets > 0) ? m_pellets - 1 : 0;
            if (m_pellets == 0) m_lc = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_score"},   32'(o_score),        32'(m_score));
        check({tag, "_pellets"}, 32'(o_pellets_left), 32'(m_pellets));
        check({tag, "_lclear"},  32'(o_level_clear),  32'(m_lc));
    endtask

    // One full tick transaction; called at a negedge with tick low
    task automatic do_txn(input int x, input int y, input bit v,
                          input int exp_rd, input int exp_wr, input string tag);
        int r0, w0, e0;
        mem[x][y] = v;
        r0 = rd_cnt; w0 = wr_cnt; e0 = eat_cnt;
        i_tick = 1'b1; i_pac_x = 6'(x); i_pac_y = 5'(y);
        @(negedge i_clk);
        i_tick = 1'b0;
        repeat (2) @(negedge i_clk);
        check({tag, "_busyT3"}, 32'(o_busy), 32'(exp_wr));
        @(negedge i_clk);
        model_tick(x, v);
        check({tag, "_reads"},  32'(rd_cnt - r0),  32'(exp_rd));
        check({tag, "_writes"}, 32'(wr_cnt - w0),  32'(exp_wr));
        check({tag, "_eats"},   32'(eat_cnt - e0), 32'(exp_wr));
        check({tag, "_busy"},   32'(o_busy),       32'(0));
        if (exp_wr != 0) begin
            check({tag, "_wr_x"}, 32'(last_wx), 32'(x));
            check({tag, "_wr_y"}, 32'(last_wy), 32'(y));
        end
        check_state(tag);
    endtask

    task automatic pulse_new_level();
        i_new_level = 1'b1;
        @(negedge i_clk);
        i_new_level = 1'b0;
        m_pellets = PT;
        m_lc      = 1'b0;
    endtask

    typedef struct {
        int x;
        int y;
        bit v;
        int exp_rd;
        int exp_wr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int r0, w0, e0, x, y;
        bit v;

        tbl[0] = '{3,  1,  1'b1, 1, 1};
        tbl[1] = '{10, 5,  1'b0, 1, 0};
        tbl[2] = '{49, 31, 1'b1, 1, 1};
        tbl[3] = '{50, 0,  1'b1, 0, 0};
        tbl[4] = '{55, 3,  1'b1, 0, 0};
        tbl[5] = '{63, 31, 1'b1, 0, 0};
        tbl[6] = '{0,  0,  1'b1, 1, 1};
        tbl[7] = '{49, 0,  1'b0, 1, 0};

        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++)
                mem[i][j] = 1'b0;

        // Reset values while reset is held
        repeat (3) @(negedge i_clk);
        check("rst_busy",    32'(o_busy),         32'(0));
        check("rst_eaten",   32'(o_eaten),        32'(0));
        check("rst_map_en",  32'(o_map_en),       32'(0));
        check("rst_map_x",   32'(o_map_x),        32'(0));
        check("rst_map_y",   32'(o_map_y),        32'(0));
        check_state("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Cycle-accurate eat at (3,1)
        mem[3][1] = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt;
        i_tick = 1'b1; i_pac_x = 6'd3; i_pac_y = 5'd1;
        @(negedge i_clk);
        i_tick = 1'b0;
        check("t1_en",    32'(o_map_en),    32'(1));
        check("t1_wr",    32'(o_map_write), 32'(0));
        check("t1_x",     32'(o_map_x),     32'(3));
        check("t1_y",     32'(o_map_y),     32'(1));
        @(negedge i_clk);
        check("t2_en",    32'(o_map_en),    32'(0));
        check("t2_busy",  32'(o_busy),      32'(1));
        @(negedge i_clk);
        check("t3_en",    32'(o_map_en),    32'(1));
        check("t3_wr",    32'(o_map_write), 32'(1));
        check("t3_eaten", 32'(o_eaten),     32'(1));
        @(negedge i_clk);
        model_tick(3, 1'b1);
        check("t4_eaten", 32'(o_eaten),     32'(0));
        check("t4_reads", 32'(rd_cnt - r0), 32'(1));
        check("t4_wrs",   32'(wr_cnt - w0), 32'(1));
        check("t4_score_10",   32'(o_score),        32'(10));
        check("t4_pellets599", 32'(o_pellets_left), 32'(599));

        // Table of single transactions
        for (int i = 0; i < 8; i++)
            do_txn(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].exp_rd, tbl[i].exp_wr,
                   $sformatf("tbl%0d", i));

        // Ticks while busy are dropped
        mem[4][2] = 1'b1; mem[7][3] = 1'b1; mem[8][3] = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt;
        i_tick = 1'b1; i_pac_x = 6'd4; i_pac_y = 5'd2;
        @(negedge i_clk);
        i_pac_x = 6'd7; i_pac_y = 5'd3;
        check("drop_x1", 32'(o_map_x), 32'(4));
        @(negedge i_clk);
        i_pac_x = 6'd8;
        check("drop_x2", 32'(o_map_x), 32'(4));
        @(negedge i_clk);
        i_tick = 1'b0;
        check("drop_x3", 32'(o_map_x), 32'(4));
        check("drop_y3", 32'(o_map_y), 32'(2));
        @(negedge i_clk);
        model_tick(4, 1'b1);
        check("drop_reads", 32'(rd_cnt - r0), 32'(1));
        check("drop_wrs",   32'(wr_cnt - w0), 32'(1));
        check("drop_busy",  32'(o_busy),      32'(0));
        check_state("drop");

        // New level during CLEAR: write happens, no score/count update
        mem[5][5] = 1'b1;
        w0 = wr_cnt; e0 = m_score;
        i_tick = 1'b1; i_pac_x = 6'd5; i_pac_y = 5'd5;
        @(negedge i_clk);
        i_tick = 1'b0;
        repeat (2) @(negedge i_clk);
        check("nlc_wr", 32'(o_map_write), 32'(1));
        pulse_new_level();
        check("nlc_writes", 32'(wr_cnt - w0), 32'(1));
        check("nlc_busy",   32'(o_busy),      32'(0));
        check("nlc_score_kept", 32'(o_score), 32'(e0));
        check_state("nlc");

        // Reset asserted during EVAL aborts with no write
        mem[6][6] = 1'b1;
        w0 = wr_cnt;
        i_tick = 1'b1; i_pac_x = 6'd6; i_pac_y = 5'd6;
        @(negedge i_clk);
        i_tick = 1'b0;
        @(negedge i_clk);
        check("arst_in_eval", 32'(o_busy), 32'(1));
        #1 i_rst_n = 1'b0;
        #1;
        m_score = 0; m_pellets = PT; m_lc = 1'b0;
        check("arst_en",    32'(o_map_en), 32'(0));
        check("arst_busy",  32'(o_busy),   32'(0));
        check("arst_eaten", 32'(o_eaten),  32'(0));
        check("arst_x",     32'(o_map_x),  32'(0));
        check("arst_y",     32'(o_map_y),  32'(0));
        check_state("arst");
        repeat (3) @(negedge i_clk);
        check("arst_writes", 32'(wr_cnt - w0), 32'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        do_txn(55, 4, 1'b1, 0, 0, "x55");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            x = int'($urandom_range(0, 63));
            y = int'($urandom_range(0, 31));
            v = 1'($urandom_range(0, 1));
            do_txn(x, y, v, (x < MAP_W) ? 1 : 0, (x < MAP_W && v) ? 1 : 0, "rnd");
            if ($urandom_range(0, 19) == 0) begin
                pulse_new_level();
                check_state("rnd_nl");
            end
        end

        // Drain all pellets, one extra eat, then a new level
        while (m_pellets > 0)
            do_txn(int'($urandom_range(0, 49)), int'($urandom_range(0, 31)), 1'b1, 1, 1, "drain");
        check("drain_lclear", 32'(o_level_clear), 32'(1));
        do_txn(1, 1, 1'b1, 1, 1, "over");
        check("over_pellets0", 32'(o_pellets_left), 32'(0));
        e0 = m_score;
        pulse_new_level();
        check("nl_pellets", 32'(o_pellets_left), 32'(PT));
        check("nl_lclear",  32'(o_level_clear),  32'(0));
        check("nl_score",   32'(o_score),        32'(e0));

        // Saturation of the score
        while (m_score < 65530)
            do_txn(int'($urandom_range(0, 49)), int'($urandom_range(0, 31)), 1'b1, 1, 1, "sat");
        do_txn(2, 2, 1'b1, 1, 1, "sat1");
        check("sat_ffff_a", 32'(o_score), 32'hFFFF);
        do_txn(2, 3, 1'b1, 1, 1, "sat2");
        check("sat_ffff_b", 32'(o_score), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
